// File: rtl/streebog_pkg.sv
// rtl/streebog_pkg.sv - shared constants and types for the Streebog block feeder
//
// Purpose: block geometry, length widths, FSM state encoding and the
// pending-pad-block flag used by streebog_feeder and streebog_pad.
// Ports: none (package).

package streebog_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int N_FULL      = 512;
  localparam int LEN_W       = 10;
  localparam int IDX_W       = 7;

  // idx counts 0..64, so it needs one bit more than a lane number
  localparam logic [IDX_W-1:0] IDX_ONE  = 7'd1;
  localparam logic [IDX_W-1:0] IDX_FULL = 7'd64;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SEND,
    WAIT_HASH,
    OUT,
    RELEASE
  } state_t;

  // Set when a message ended exactly on a block boundary and the
  // all-padding block still has to follow the full one.
  typedef enum logic {
    PAD_NONE,
    PAD_PENDING
  } pad_flag_t;

endpackage

// File: rtl/streebog_pad.sv
// rtl/streebog_pad.sv - lane mask and 0x01 pad insertion for a message block
//
// Purpose: keeps byte lanes below n, writes 8'h01 into lane n and zeroes
// every lane above it. n = 64 passes the block unchanged; n = 0 yields the
// all-padding block 512'h1.
// Ports:
//   block   in  N_FULL  raw block, byte k in bits [8k+7:8k]
//   n       in  IDX_W   number of message bytes held in block (0..64)
//   padded  out N_FULL  padded block

module streebog_pad
  import streebog_pkg::*;
(
  input  logic [N_FULL-1:0] block,
  input  logic [IDX_W-1:0]  n,
  output logic [N_FULL-1:0] padded
);

  always_comb begin
    padded = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (k < int'(n)) begin
        padded[8*k +: 8] = block[8*k +: 8];
      end else if (k == int'(n)) begin
        padded[8*k +: 8] = 8'h01;
      end
    end
  end

endmodule

// File: rtl/streebog_feeder.sv
// rtl/streebog_feeder.sv - byte stream to padded 512-bit blocks for a Streebog core
//
// Purpose: packs host bytes into message blocks, pads the final block,
// drives the core block and start handshakes, and re-presents the finished
// hash to the host (upper half only, shifted down, in 256-bit mode).
// Optional feature macro: STREEBOG_FEEDER_BE_EN - when defined h_data_o is
// byte-reversed (lane 0 carries the most significant hash byte).
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   mode_i                        1 = 512-bit hash, 0 = 256-bit (latched on first byte)
//   s_data_i/s_valid_i/s_ready_o  host byte stream, s_last_i marks the final byte
//   mes_o/mes_valid_o/mes_ready_i block to core, with mes_last_o and mes_last_len_o
//   hash_len_o                    latched mode for the core
//   fsm_start_req_o/_ack_i        message-in-flight request/acknowledge
//   hash_i/hash_valid_i/hash_ready_o  core result capture
//   h_data_o/h_valid_o/h_ready_i  hash to host
//   msg_bytes_o                   byte count of current/last message (saturating)

module streebog_feeder
  import streebog_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mode_i,
  input  logic [7:0]            s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  s_last_i,
  output logic [DATA_WIDTH-1:0] mes_o,
  output logic                  mes_valid_o,
  input  logic                  mes_ready_i,
  output logic                  mes_last_o,
  output logic [LEN_W-1:0]      mes_last_len_o,
  output logic                  hash_len_o,
  output logic                  fsm_start_req_o,
  input  logic                  fsm_start_ack_i,
  input  logic [DATA_WIDTH-1:0] hash_i,
  input  logic                  hash_valid_i,
  output logic                  hash_ready_o,
  output logic [DATA_WIDTH-1:0] h_data_o,
  output logic                  h_valid_o,
  input  logic                  h_ready_i,
  output logic [CNT_W-1:0]      msg_bytes_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t                  state, state_nxt;
  pad_flag_t               pad_pend;
  logic [IDX_W-1:0]        idx, n_next, pad_n;
  logic [DATA_WIDTH-1:0]   blk, blk_wr, pad_in, pad_out;
  logic [DATA_WIDTH-1:0]   h_data, h_fmt;
  logic [LEN_W-1:0]        last_len;
  logic [CNT_W-1:0]        cnt;
  logic                    mode, req, mes_valid, mes_last, hash_rdy, h_valid;
  logic                    s_ready, acc, mes_hs, out_hs;

  // Gated by rst_i so that every output reads 0 while reset is held.
  assign s_ready = !rst_i && ((state == IDLE && !fsm_start_ack_i) || state == FILL);
  assign acc     = s_valid_i && s_ready;
  assign mes_hs  = mes_valid && mes_ready_i;
  assign out_hs  = h_valid && h_ready_i;
  assign n_next  = idx + IDX_ONE;

  always_comb begin
    blk_wr = blk;
    blk_wr[{idx[5:0], 3'b000} +: 8] = s_data_i;
  end

  // One pad unit serves both the short final block (block with the new byte,
  // n = idx+1) and the trailing all-padding block (current block, n = 0).
  assign pad_in = (state == SEND) ? blk : blk_wr;
  assign pad_n  = (state == SEND) ? '0  : n_next;

  streebog_pad u_pad (
    .block  (pad_in),
    .n      (pad_n),
    .padded (pad_out)
  );

  always_comb begin
`ifdef STREEBOG_FEEDER_BE_EN
    h_fmt = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (mode || k < BLOCK_BYTES / 2) begin
        h_fmt[8*k +: 8] = hash_i[8*(BLOCK_BYTES-1-k) +: 8];
      end
    end
`else
    h_fmt = mode ? hash_i : {{(DATA_WIDTH/2){1'b0}}, hash_i[DATA_WIDTH-1:DATA_WIDTH/2]};
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FILL: begin
        if (acc) begin
          state_nxt = (s_last_i || n_next == IDX_FULL) ? SEND : FILL;
        end
      end
      SEND: begin
        if (mes_hs) begin
          if (mes_last) begin
            state_nxt = WAIT_HASH;
          end else if (pad_pend == PAD_PENDING) begin
            state_nxt = SEND;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      WAIT_HASH: begin
        if (hash_valid_i) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_hs) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!fsm_start_ack_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx       <= '0;
      blk       <= '0;
      pad_pend  <= PAD_NONE;
      mode      <= 1'b0;
      req       <= 1'b0;
      cnt       <= '0;
      mes_valid <= 1'b0;
      mes_last  <= 1'b0;
      last_len  <= '0;
      hash_rdy  <= 1'b0;
      h_valid   <= 1'b0;
      h_data    <= '0;
    end else begin
      hash_rdy <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (acc) begin
            if (state == IDLE) begin
              mode <= mode_i;
              req  <= 1'b1;
              cnt  <= CNT_ONE;
            end else if (cnt != '1) begin
              cnt <= cnt + CNT_ONE;
            end
            if (s_last_i && n_next != IDX_FULL) begin
              blk       <= pad_out;
              mes_last  <= 1'b1;
              last_len  <= {n_next, 3'b000};
              pad_pend  <= PAD_NONE;
              mes_valid <= 1'b1;
            end else if (s_last_i || n_next == IDX_FULL) begin
              // Full block; a final byte here leaves the pad block pending.
              blk       <= blk_wr;
              mes_last  <= 1'b0;
              last_len  <= '0;
              pad_pend  <= s_last_i ? PAD_PENDING : PAD_NONE;
              mes_valid <= 1'b1;
            end else begin
              blk <= blk_wr;
              idx <= n_next;
            end
          end
        end
        SEND: begin
          if (mes_hs) begin
            mes_valid <= 1'b0;
            idx       <= '0;
            if (!mes_last && pad_pend == PAD_PENDING) begin
              blk      <= pad_out;
              mes_last <= 1'b1;
              last_len <= '0;
              pad_pend <= PAD_NONE;
            end
          end else if (!mes_valid) begin
            // Pad block loaded last cycle: present it now.
            mes_valid <= 1'b1;
          end
        end
        WAIT_HASH: begin
          if (hash_valid_i) begin
            h_data   <= h_fmt;
            hash_rdy <= 1'b1;
            h_valid  <= 1'b1;
          end
        end
        OUT: begin
          if (out_hs) begin
            h_valid <= 1'b0;
            req     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_ready_o       = s_ready;
  assign mes_o           = blk;
  assign mes_valid_o     = mes_valid;
  assign mes_last_o      = mes_last;
  assign mes_last_len_o  = last_len;
  assign hash_len_o      = mode;
  assign fsm_start_req_o = req;
  assign hash_ready_o    = hash_rdy;
  assign h_data_o        = h_data;
  assign h_valid_o       = h_valid;
  assign msg_bytes_o     = cnt;

endmodule

// File: tb/tb_streebog_feeder.sv
// tb/tb_streebog_feeder.sv - self-checking bench for streebog_feeder

module tb_streebog_feeder;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         mode_i = 1'b0;
  logic [7:0]   s_data_i = '0;
  logic         s_valid_i = 1'b0;
  logic         s_ready_o;
  logic         s_last_i = 1'b0;
  logic [511:0] mes_o;
  logic         mes_valid_o;
  logic         mes_ready_i = 1'b0;
  logic         mes_last_o;
  logic [9:0]   mes_last_len_o;
  logic         hash_len_o;
  logic         fsm_start_req_o;
  logic         fsm_start_ack_i = 1'b0;
  logic [511:0] hash_i = '0;
  logic         hash_valid_i = 1'b0;
  logic         hash_ready_o;
  logic [511:0] h_data_o;
  logic         h_valid_o;
  logic         h_ready_i = 1'b0;
  logic [31:0]  msg_bytes_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  streebog_feeder dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .mode_i          (mode_i),
    .s_data_i        (s_data_i),
    .s_valid_i       (s_valid_i),
    .s_ready_o       (s_ready_o),
    .s_last_i        (s_last_i),
    .mes_o           (mes_o),
    .mes_valid_o     (mes_valid_o),
    .mes_ready_i     (mes_ready_i),
    .mes_last_o      (mes_last_o),
    .mes_last_len_o  (mes_last_len_o),
    .hash_len_o      (hash_len_o),
    .fsm_start_req_o (fsm_start_req_o),
    .fsm_start_ack_i (fsm_start_ack_i),
    .hash_i          (hash_i),
    .hash_valid_i    (hash_valid_i),
    .hash_ready_o    (hash_ready_o),
    .h_data_o        (h_data_o),
    .h_valid_o       (h_valid_o),
    .h_ready_i       (h_ready_i),
    .msg_bytes_o     (msg_bytes_o)
  );

  logic [7:0]   msg_q[$];
  logic [511:0] exp_data[$];
  logic         exp_last[$];
  logic [9:0]   exp_len[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: message split into 64-byte blocks; the tail gets 0x01 then
  // zeros, and a length that is a multiple of 64 gets an extra 512'h1 block.
  task automatic build_expected();
    int n, nfull, r;
    logic [511:0] d;
    exp_data.delete();
    exp_last.delete();
    exp_len.delete();
    n = msg_q.size();
    nfull = n / 64;
    r = n % 64;
    for (int b = 0; b < nfull; b++) begin
      d = '0;
      for (int k = 0; k < 64; k++) d[8*k +: 8] = msg_q[64*b + k];
      exp_data.push_back(d);
      exp_last.push_back(1'b0);
      exp_len.push_back(10'd0);
    end
    d = '0;
    if (r == 0) begin
      d[7:0] = 8'h01;
      exp_len.push_back(10'd0);
    end else begin
      for (int k = 0; k < r; k++) d[8*k +: 8] = msg_q[64*nfull + k];
      d[8*r +: 8] = 8'h01;
      exp_len.push_back(10'(8 * r));
    end
    exp_data.push_back(d);
    exp_last.push_back(1'b1);
  endtask

  function automatic logic [511:0] exp_hash(input logic [511:0] h, input bit m);
    return m ? h : (h >> 256);
  endfunction

  function automatic logic [511:0] rand_hash();
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[32*i +: 32] = $urandom();
    return h;
  endfunction

  task automatic fill_random(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(255)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 512'(s_ready_o), 512'(0));
    chk({tag, "_mes_valid"}, 512'(mes_valid_o), 512'(0));
    chk({tag, "_mes"}, mes_o, 512'(0));
    chk({tag, "_mes_last"}, 512'(mes_last_o), 512'(0));
    chk({tag, "_mes_len"}, 512'(mes_last_len_o), 512'(0));
    chk({tag, "_req"}, 512'(fsm_start_req_o), 512'(0));
    chk({tag, "_hash_len"}, 512'(hash_len_o), 512'(0));
    chk({tag, "_hash_ready"}, 512'(hash_ready_o), 512'(0));
    chk({tag, "_h_valid"}, 512'(h_valid_o), 512'(0));
    chk({tag, "_h_data"}, h_data_o, 512'(0));
    chk({tag, "_msg_bytes"}, 512'(msg_bytes_o), 512'(0));
  endtask

  // Plays host and core for one message held in msg_q.
  task automatic run_message(input bit mode, input logic [511:0] hash, input bit slow);
    int n, pos, got, cycles, mv_cnt, hvc;
    bit done, hash_taken, prev_mv, prev_hv;
    logic [511:0] prev_mes;
    logic prev_last;
    logic [9:0] prev_len;
    build_expected();
    n = msg_q.size();
    pos = 0; got = 0; cycles = 0; mv_cnt = 0; hvc = 0;
    done = 0; hash_taken = 0; prev_mv = 0; prev_hv = 0;
    prev_mes = '0; prev_last = 0; prev_len = '0;
    while (!done && cycles < 5000) begin
      @(negedge clk_i);
      cycles++;
      fsm_start_ack_i = fsm_start_req_o;
      mode_i = mode;
      s_valid_i = (pos < n) && ($urandom_range(3) != 0);
      s_data_i = (pos < n) ? msg_q[pos] : 8'h00;
      s_last_i = (pos == n - 1);
      mes_ready_i = slow ? (mv_cnt >= 5) : ($urandom_range(2) != 0);
      hash_valid_i = (got == exp_data.size()) && !hash_taken;
      hash_i = hash;
      h_ready_i = slow ? (hvc >= 3) : ($urandom_range(1) == 1);
      #1;
      if (mes_valid_o && prev_mv) begin
        chk("mes_hold", mes_o, prev_mes);
        chk("last_hold", 512'(mes_last_o), 512'(prev_last));
        chk("len_hold", 512'(mes_last_len_o), 512'(prev_len));
      end
      if (mes_valid_o) chk("s_ready_send", 512'(s_ready_o), 512'(0));
      if (prev_hv) chk("h_valid_hold", 512'(h_valid_o), 512'(1));
      if (s_valid_i && s_ready_o) pos++;
      prev_mv = 0;
      prev_hv = 0;
      if (mes_valid_o) begin
        if (mes_ready_i) begin
          if (got < exp_data.size()) begin
            chk("blk_data", mes_o, exp_data[got]);
            chk("blk_last", 512'(mes_last_o), 512'(exp_last[got]));
            chk("blk_len", 512'(mes_last_len_o), 512'(exp_len[got]));
          end else begin
            chk("extra_block", 512'(1), 512'(0));
          end
          got++;
          mv_cnt = 0;
        end else begin
          prev_mv = 1;
          prev_mes = mes_o;
          prev_last = mes_last_o;
          prev_len = mes_last_len_o;
          mv_cnt++;
        end
      end
      if (hash_ready_o) hash_taken = 1;
      if (h_valid_o) begin
        chk("s_ready_out", 512'(s_ready_o), 512'(0));
        if (h_ready_i) begin
          chk("h_data", h_data_o, exp_hash(hash, mode));
          chk("msg_bytes", 512'(msg_bytes_o), 512'(n));
          chk("hash_len", 512'(hash_len_o), 512'(mode));
          chk("blk_count", 512'(got), 512'(exp_data.size()));
          done = 1;
        end else begin
          prev_hv = 1;
          hvc++;
        end
      end
    end
    if (!done) chk("timeout", 512'(0), 512'(1));
    @(negedge clk_i);
    s_valid_i = 0;
    s_last_i = 0;
    h_ready_i = 0;
    hash_valid_i = 0;
    mes_ready_i = 0;
    fsm_start_ack_i = fsm_start_req_o;
  endtask

  initial begin
    #1;
    check_reset_outputs("rst");
    @(negedge clk_i);
    rst_i = 0;

    // single byte, 512-bit mode
    msg_q.delete();
    msg_q.push_back(8'hAB);
    run_message(1'b1, rand_hash(), 1'b0);

    // exactly one block of 0x00..0x3F, with stalled core ready
    msg_q.delete();
    for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
    run_message(1'b1, rand_hash(), 1'b1);

    // 65 bytes
    fill_random(65);
    run_message(1'b0, rand_hash(), 1'b0);

    // 256-bit mode with the A/5 pattern and stalled host ready
    fill_random(int'($urandom_range(1, 130)));
    run_message(1'b0, {{64{4'hA}}, {64{4'h5}}}, 1'b1);

    // core acknowledge stuck high after the hash is delivered
    fill_random(10);
    run_message(1'b1, rand_hash(), 1'b0);
    fsm_start_ack_i = 1;
    s_valid_i = 1;
    s_data_i = 8'h55;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      #1;
      chk("stuck_req", 512'(fsm_start_req_o), 512'(0));
      chk("stuck_s_ready", 512'(s_ready_o), 512'(0));
    end
    @(negedge clk_i);
    fsm_start_ack_i = 0;
    s_valid_i = 0;
    @(negedge clk_i);
    #1;
    chk("ack_released_s_ready", 512'(s_ready_o), 512'(1));

    // reset in the middle of FILL
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      mode_i = 1;
      s_valid_i = 1;
      s_last_i = 0;
      s_data_i = 8'($urandom_range(255));
    end
    @(negedge clk_i);
    s_valid_i = 0;
    rst_i = 1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_i);
    rst_i = 0;

    // randomized messages after the abort
    for (int m = 0; m < 6; m++) begin
      fill_random(int'($urandom_range(1, 200)));
      run_message(1'($urandom_range(1)), rand_hash(), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
